// File: rtl/timer_irq_unit_pkg.sv
// Shared constants and types for the Count/Compare timer.
// Build option TIMER_DIV2_EN selects the half-rate Count.
package timer_irq_unit_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] UNKNOW = 32'hDEAD_BEEF;

  typedef enum logic {
    RUN  = 1'b0,
    STOP = 1'b1
  } tstate_e;

  function automatic logic [DATA_W-1:0] cnt_inc(
    input logic [DATA_W-1:0] v
  );
    return v + {{(DATA_W-1){1'b0}}, 1'b1};
  endfunction

endpackage

// File: rtl/timer_irq_unit_flop.sv
// Shared enable flop with asynchronous active-low reset.
// Used for Count, the irq flag and the prescaler phase.
module en_rst_flop #(
  parameter int            W       = 1,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/timer_irq_unit_tick_gen.sv
// Count prescaler; TIMER_DIV2_EN gives one tick per two run cycles.
// Without it every run cycle ticks and no phase flop exists.
module tick_gen (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

`ifdef TIMER_DIV2_EN
  logic phase_q;
  logic phase_d;

  // a Count write restarts the divider so the next tick is two cycles out
  assign phase_d = clr ? 1'b0 : ~phase_q;

  en_rst_flop #(
    .W      (1),
    .RST_VAL(1'b0)
  ) u_phase (
    .clk(clk),
    .rst(rst),
    .en (en | clr),
    .d  (phase_d),
    .q  (phase_q)
  );

  assign tick = en & phase_q & ~clr;
`else
  logic unused_ok;

  assign unused_ok = clk ^ rst;
  assign tick      = en & ~clr;
`endif

endmodule

// File: rtl/timer_irq_unit.sv
// CP0 Count register with Compare match interrupt (IP7).
// Build option TIMER_DIV2_EN halves the Count rate.
import timer_irq_unit_pkg::*;

module timer_irq_unit (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_s,
  input  logic [DATA_W-1:0] write_data,
  input  logic              r_p,
  input  logic              r_h,
  input  logic [DATA_W-1:0] compare,
  input  logic              compare_we,
  input  logic              count_dis,
  output logic [DATA_W-1:0] read_data,
  output logic              timer_irq
);

  tstate_e           state_q;
  tstate_e           state_d;
  logic              run;
  logic              tick;
  logic [DATA_W-1:0] count_q;
  logic [DATA_W-1:0] count_d;
  logic [DATA_W-1:0] count_nxt;
  logic              irq_set;
  logic              irq_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (count_dis)  state_d = STOP;
      STOP:    if (!count_dis) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    run = 1'b0;
    unique case (state_q)
      RUN:     run = 1'b1;
      default: run = 1'b0;
    endcase
  end

  tick_gen u_tick_gen (
    .clk (clk),
    .rst (rst),
    .en  (run),
    .clr (we_s),
    .tick(tick)
  );

  assign count_nxt = cnt_inc(count_q);
  assign count_d   = we_s ? write_data : count_nxt;

  en_rst_flop #(
    .W      (DATA_W),
    .RST_VAL('0)
  ) u_count (
    .clk(clk),
    .rst(rst),
    .en (we_s | tick),
    .d  (count_d),
    .q  (count_q)
  );

  // only a counting step can raise the flag, never a software load
  assign irq_set = tick & ~we_s & (count_nxt == compare);
  assign irq_d   = compare_we ? 1'b0 : (timer_irq | irq_set);

  en_rst_flop #(
    .W      (1),
    .RST_VAL(1'b0)
  ) u_irq (
    .clk(clk),
    .rst(rst),
    .en (1'b1),
    .d  (irq_d),
    .q  (timer_irq)
  );

  assign read_data = (r_p | r_h) ? count_q : UNKNOW;

endmodule
